// File: rtl/seg7_disp_sched.sv
// seg7_disp_sched: round-robin scheduler sharing one seg7dec decoder among
// NUM_REQ requesters. A granted requester's value/mode are driven to the
// decoder, held for HOLD_CYCLES edges, then the decoder's Hex/Hex1 outputs
// are captured into that requester's display registers and ack pulses.
//
// Optional feature, macro SEG7_SHADOW_SKIP_EN: keep a per-requester shadow
// copy of the last captured val/mode; a repeat request with identical
// val/mode is acknowledged in one cycle without touching the decoder.
module seg7_disp_sched #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [5*NUM_REQ-1:0]   req_val,
    input  logic [NUM_REQ-1:0]     req_mode,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   busy,
    output logic [4:0]             dec_val,
    output logic                   dec_con,
    input  logic [6:0]             dec_hex,
    input  logic [6:0]             dec_hex1,
    output logic [7*NUM_REQ-1:0]   disp_lo,
    output logic [7*NUM_REQ-1:0]   disp_hi
);

    localparam int                IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0]        CNT_LOAD  = 4'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]  LAST_INIT = IDX_W'(NUM_REQ - 1);
    localparam logic [6:0]        BLANK     = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HIT    = 2'd2
    } state_t;

    state_t             state;
    state_t             nxt_state;
    logic [3:0]         cnt;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   grant;

    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [4:0]         pick_val;
    logic               pick_mode;
    logic               hit;
    logic               load;
    logic               enter_hit;
    logic               capture;
    logic               hit_done;

`ifdef SEG7_SHADOW_SKIP_EN
    logic [NUM_REQ-1:0] shadow_valid;
    logic [NUM_REQ-1:0] shadow_mode;
    logic [4:0]         shadow_val [NUM_REQ];
`endif

    // Round-robin pick, shadow-hit test and next-state decode.
    always_comb begin
        found     = 1'b0;
        pick      = '0;
        nxt_state = state;
        load      = 1'b0;
        enter_hit = 1'b0;
        capture   = 1'b0;
        hit_done  = 1'b0;
        hit       = 1'b0;

        // Search upward from last_grant+1 so the last served requester
        // ends up with the lowest priority.
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [IDX_W-1:0] idx;
            idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end

        pick_val  = req_val[5*pick +: 5];
        pick_mode = req_mode[pick];

`ifdef SEG7_SHADOW_SKIP_EN
        hit = shadow_valid[pick] && (shadow_val[pick] == pick_val) &&
              (shadow_mode[pick] == pick_mode);
`endif

        case (state)
            S_IDLE: begin
                if (found) begin
                    if (hit) begin
                        nxt_state = S_HIT;
                        enter_hit = 1'b1;
                    end else begin
                        nxt_state = S_SETTLE;
                        load      = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (cnt == 4'd0) begin
                    nxt_state = S_IDLE;
                    capture   = 1'b1;
                end
            end
            S_HIT: begin
                nxt_state = S_IDLE;
                hit_done  = 1'b1;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // Control state: FSM, settle counter, grant bookkeeping, decoder drive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            busy       <= 1'b0;
            ack        <= '0;
            last_grant <= LAST_INIT;
            grant      <= '0;
            dec_val    <= 5'd0;
            dec_con    <= 1'b0;
        end else begin
            state <= nxt_state;
            ack   <= '0;
            if (load) begin
                dec_val <= pick_val;
                dec_con <= pick_mode;
                grant   <= pick;
                cnt     <= CNT_LOAD;
                busy    <= 1'b1;
            end else if (enter_hit) begin
                grant <= pick;
                busy  <= 1'b1;
            end else if (state == S_SETTLE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (capture || hit_done) begin
                ack[grant] <= 1'b1;
                last_grant <= grant;
                busy       <= 1'b0;
            end
        end
    end

    // Display registers: only the granted slice is written on capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_lo <= {NUM_REQ{BLANK}};
            disp_hi <= {NUM_REQ{BLANK}};
        end else if (capture) begin
            disp_lo[7*grant +: 7] <= dec_hex;
            disp_hi[7*grant +: 7] <= dec_hex1;
        end
    end

`ifdef SEG7_SHADOW_SKIP_EN
    // Shadow copy of what was last decoded for each requester.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_valid <= '0;
        end else if (capture) begin
            shadow_valid[grant] <= 1'b1;
            shadow_mode[grant]  <= dec_con;
            shadow_val[grant]   <= dec_val;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_disp_sched.sv
// tb_seg7_disp_sched: directed bench for seg7_disp_sched with a behavioural
// seg7dec attached to the decoder port. Covers SEG7_SHADOW_SKIP_EN builds too.
module tb_seg7_disp_sched;

    localparam int NUM_REQ = 4;
    localparam int HOLD    = 2;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req;
    logic [5*NUM_REQ-1:0]  req_val;
    logic [NUM_REQ-1:0]    req_mode;
    logic [NUM_REQ-1:0]    ack;
    logic                  busy;
    logic [4:0]            dec_val;
    logic                  dec_con;
    logic [6:0]            dec_hex;
    logic [6:0]            dec_hex1;
    logic [7*NUM_REQ-1:0]  disp_lo;
    logic [7*NUM_REQ-1:0]  disp_hi;

    int checks = 0;
    int errors = 0;

    seg7_disp_sched #(.NUM_REQ(NUM_REQ), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_val(req_val),
        .req_mode(req_mode), .ack(ack), .busy(busy), .dec_val(dec_val),
        .dec_con(dec_con), .dec_hex(dec_hex), .dec_hex1(dec_hex1),
        .disp_lo(disp_lo), .disp_hi(disp_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'h0: seg = 7'b1000000; 4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100; 4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001; 4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010; 4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000; 4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000; 4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110; 4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110; default: seg = 7'b0001110;
        endcase
    endfunction

    // Behavioural seg7dec: hex mode shows bit 4 as a leading '1',
    // decimal mode shows tens (blank when zero).
    always_comb begin
        if (dec_con) begin
            dec_hex  = seg(dec_val[3:0]);
            dec_hex1 = dec_val[4] ? seg(4'h1) : BLANK;
        end else begin
            dec_hex  = seg(4'(dec_val % 10));
            dec_hex1 = (dec_val / 10 == 0) ? BLANK : seg(4'(dec_val / 10));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (ack == '0 && cyc < 20);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = 4'hF; req_val = '1; req_mode = 4'hF;
        tick(2);
        rst_n = 1'b1; req = 4'h0;
        tick(1);
        checks++; if (disp_lo !== {NUM_REQ{BLANK}}) begin errors++; $display("FAIL reset_disp_lo got=%h exp=%h", disp_lo, {NUM_REQ{BLANK}}); end
        checks++; if (disp_hi !== {NUM_REQ{BLANK}}) begin errors++; $display("FAIL reset_disp_hi got=%h exp=%h", disp_hi, {NUM_REQ{BLANK}}); end
        checks++; if (ack !== 4'h0) begin errors++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (dec_val !== 5'd0) begin errors++; $display("FAIL reset_dec_val got=%0d exp=0", dec_val); end
        checks++; if (dec_con !== 1'b0) begin errors++; $display("FAIL reset_dec_con got=%b exp=0", dec_con); end
    endtask

    task automatic test_single_hex;
        req_val = '0; req_val[4:0] = 5'd5; req_mode = 4'b0001; req = 4'b0001;
        tick(1);
        checks++; if (dec_val !== 5'd5) begin errors++; $display("FAIL single_dec_val got=%0d exp=5", dec_val); end
        checks++; if (dec_con !== 1'b1) begin errors++; $display("FAIL single_dec_con got=%b exp=1", dec_con); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
        tick(1);
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_early_ack got=%b exp=0000", ack); end
        tick(1);
        req = 4'b0000;
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL single_ack got=%b exp=0001", ack); end
        checks++; if (disp_lo[6:0] !== 7'b0010010) begin errors++; $display("FAIL single_disp_lo got=%b exp=0010010", disp_lo[6:0]); end
        checks++; if (disp_hi[6:0] !== 7'b1111111) begin errors++; $display("FAIL single_disp_hi got=%b exp=1111111", disp_hi[6:0]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_done got=%b exp=0", busy); end
        tick(1);
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_pulse got=%b exp=0000", ack); end
        checks++; if (dec_val !== 5'd5) begin errors++; $display("FAIL single_dec_val_hold got=%0d exp=5", dec_val); end
    endtask

    task automatic test_decimal_hex;
        int cyc;
        req_val[9:5] = 5'd23; req_mode[1] = 1'b0; req = 4'b0010;
        wait_ack(cyc);
        req = 4'b0000;
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL dec23_ack got=%b exp=0010", ack); end
        checks++; if (cyc !== HOLD + 1) begin errors++; $display("FAIL dec23_latency got=%0d exp=%0d", cyc, HOLD + 1); end
        checks++; if (disp_lo[13:7] !== 7'b0110000) begin errors++; $display("FAIL dec23_disp_lo got=%b exp=0110000", disp_lo[13:7]); end
        checks++; if (disp_hi[13:7] !== 7'b0100100) begin errors++; $display("FAIL dec23_disp_hi got=%b exp=0100100", disp_hi[13:7]); end
        checks++; if (disp_lo[6:0] !== 7'b0010010) begin errors++; $display("FAIL dec23_other_hold got=%b exp=0010010", disp_lo[6:0]); end
        tick(1);
        req_val[9:5] = 5'd26; req_mode[1] = 1'b1; req = 4'b0010;
        wait_ack(cyc);
        req = 4'b0000;
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL hex26_ack got=%b exp=0010", ack); end
        checks++; if (disp_lo[13:7] !== 7'b0001000) begin errors++; $display("FAIL hex26_disp_lo got=%b exp=0001000", disp_lo[13:7]); end
        checks++; if (disp_hi[13:7] !== 7'b1111001) begin errors++; $display("FAIL hex26_disp_hi got=%b exp=1111001", disp_hi[13:7]); end
        tick(1);
    endtask

    task automatic test_round_robin;
        int cyc;
        logic [NUM_REQ-1:0] exp_ack;
        rst_n = 1'b0; req = 4'hF;
        req_val = {5'd4, 5'd3, 5'd2, 5'd1}; req_mode = 4'hF;
        tick(2);
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            exp_ack = 4'b0001 << (n % 4);
            wait_ack(cyc);
            checks++; if (ack !== exp_ack) begin errors++; $display("FAIL rr_order_%0d got=%b exp=%b", n, ack, exp_ack); end
            checks++; if (cyc !== HOLD + 1) begin errors++; $display("FAIL rr_spacing_%0d got=%0d exp=%0d", n, cyc, HOLD + 1); end
        end
        checks++; if (disp_lo[27:21] !== 7'b0011001) begin errors++; $display("FAIL rr_disp_lo3 got=%b exp=0011001", disp_lo[27:21]); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        // Entered in the idle ack cycle of requester 0.
        req_val[14:10] = 5'd7; req = 4'b0100;
        tick(1);
        checks++; if (dec_val !== 5'd7) begin errors++; $display("FAIL mid_grant2_dec_val got=%0d exp=7", dec_val); end
        tick(1);
        rst_n = 1'b0;
        tick(1);
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL mid_no_ack got=%b exp=0000", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
        checks++; if (disp_lo !== {NUM_REQ{BLANK}}) begin errors++; $display("FAIL mid_disp_lo got=%h exp=%h", disp_lo, {NUM_REQ{BLANK}}); end
        checks++; if (disp_hi !== {NUM_REQ{BLANK}}) begin errors++; $display("FAIL mid_disp_hi got=%h exp=%h", disp_hi, {NUM_REQ{BLANK}}); end
        checks++; if (dec_val !== 5'd0) begin errors++; $display("FAIL mid_dec_val got=%0d exp=0", dec_val); end
        req_val[9:5] = 5'd23; req_mode[1] = 1'b0;
        rst_n = 1'b1; req = 4'b0110;
        wait_ack(cyc);
        req = 4'b0000;
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL mid_first_grant got=%b exp=0010", ack); end
        checks++; if (disp_lo[13:7] !== 7'b0110000) begin errors++; $display("FAIL mid_disp_lo1 got=%b exp=0110000", disp_lo[13:7]); end
        checks++; if (disp_lo[20:14] !== BLANK) begin errors++; $display("FAIL mid_disp_lo2 got=%b exp=1111111", disp_lo[20:14]); end
        tick(1);
    endtask

    task automatic test_repeat;
        int cyc;
        req_val[4:0] = 5'd9; req_mode[0] = 1'b0; req = 4'b0001;
        wait_ack(cyc);
        req = 4'b0000;
        checks++; if (disp_lo[6:0] !== 7'b0010000) begin errors++; $display("FAIL rep_disp_lo0 got=%b exp=0010000", disp_lo[6:0]); end
        tick(1);
        req_val[19:15] = 5'd4; req_mode[3] = 1'b1; req = 4'b1000;
        wait_ack(cyc);
        req = 4'b0000;
        checks++; if (dec_val !== 5'd4) begin errors++; $display("FAIL rep_other_dec_val got=%0d exp=4", dec_val); end
        tick(1);
        req = 4'b0001;
        wait_ack(cyc);
        req = 4'b0000;
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL rep_ack got=%b exp=0001", ack); end
        checks++; if (disp_lo[6:0] !== 7'b0010000) begin errors++; $display("FAIL rep_disp_hold got=%b exp=0010000", disp_lo[6:0]); end
`ifdef SEG7_SHADOW_SKIP_EN
        checks++; if (cyc !== 2) begin errors++; $display("FAIL rep_hit_latency got=%0d exp=2", cyc); end
        checks++; if (dec_val !== 5'd4) begin errors++; $display("FAIL rep_hit_dec_val got=%0d exp=4", dec_val); end
`else
        checks++; if (cyc !== HOLD + 1) begin errors++; $display("FAIL rep_latency got=%0d exp=%0d", cyc, HOLD + 1); end
        checks++; if (dec_val !== 5'd9) begin errors++; $display("FAIL rep_dec_val got=%0d exp=9", dec_val); end
`endif
        tick(1);
    endtask

    initial begin
        rst_n = 1'b0; req = '0; req_val = '0; req_mode = '0;
        test_reset;
        test_single_hex;
        test_decimal_hex;
        test_round_robin;
        test_reset_mid;
        test_repeat;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
